// File: rtl/isq_arbiter.sv
// Round-robin arbiter sharing one fast_inv_sqrt pipeline between N_REQ requesters.
// A tag pipe tracks which requester owns each in-flight operand so results land in the right buffer.
module isq_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [27*N_REQ-1:0]   i_x,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [26:0]           o_isq_x,
  input  logic [26:0]           i_isq_y,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [27*N_REQ-1:0]   o_rsp_data,
  input  logic [N_REQ-1:0]      i_rsp_ready,
  output logic                  o_busy
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [N_REQ-1:0] outstanding_q, outstanding_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]  tag_id_q [LATENCY];
  logic [ID_W-1:0]  tag_id_d [LATENCY];
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [26:0]      rsp_data_q [N_REQ];
  logic [26:0]      rsp_data_d [N_REQ];

  logic [26:0]      x_arr [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] handshake;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  cand;
  logic             gnt_any;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      x_arr[k] = i_x[27*k +: 27];
    end
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    eligible = i_req & ~outstanding_q;
    gnt      = '0;
    gnt_id   = '0;
    gnt_any  = 1'b0;
    cand     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((int'(rr_ptr_q) + off) % N_REQ);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (gnt_any) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    o_isq_x = '0;
    if (gnt_any) begin
      o_isq_x = x_arr[gnt_id];
    end
  end

  always_comb begin
    tag_valid_d[0] = gnt_any;
    tag_id_d[0]    = gnt_id;
    for (int i = 1; i < LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_id_d[i]    = tag_id_q[i-1];
    end
  end

  // A buffer can never be full at capture time because outstanding blocks re-issue.
  always_comb begin
    handshake     = rsp_valid_q & i_rsp_ready;
    outstanding_d = outstanding_q & ~handshake;
    rsp_valid_d   = rsp_valid_q & ~handshake;
    rsp_data_d    = rsp_data_q;
    rr_ptr_d      = rr_ptr_q;
    if (gnt_any) begin
      outstanding_d[gnt_id] = 1'b1;
      rr_ptr_d              = gnt_id;
    end
    if (tag_valid_q[LATENCY-1]) begin
      rsp_valid_d[tag_id_q[LATENCY-1]] = 1'b1;
      rsp_data_d[tag_id_q[LATENCY-1]]  = i_isq_y;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      outstanding_q <= '0;
      rr_ptr_q      <= LAST_ID;
      tag_valid_q   <= '0;
      rsp_valid_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id_q[i] <= '0;
      end
      for (int k = 0; k < N_REQ; k++) begin
        rsp_data_q[k] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
      tag_valid_q   <= tag_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      tag_id_q      <= tag_id_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      o_rsp_data[27*k +: 27] = rsp_data_q[k];
    end
  end

  assign o_gnt       = gnt;
  assign o_rsp_valid = rsp_valid_q;
  assign o_busy      = |tag_valid_q;

endmodule

// File: tb/tb_isq_arbiter.sv
// Bench for isq_arbiter: fixed-latency pipeline model plus a grant-ordered scoreboard of expected captures.
module tb_isq_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;

  typedef struct {
    int          id;
    logic [26:0] data;
    int          due;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [N-1:0]     i_req = '0;
  logic [27*N-1:0]  i_x;
  logic [N-1:0]     o_gnt;
  logic [26:0]      o_isq_x;
  logic [26:0]      i_isq_y;
  logic [N-1:0]     o_rsp_valid;
  logic [27*N-1:0]  o_rsp_data;
  logic [N-1:0]     i_rsp_ready = '0;
  logic             o_busy;

  logic [26:0]      x_arr [N];
  logic [26:0]      pipe_q [LAT];
  logic [N-1:0]     gnt_seen = '0;
  logic [N-1:0]     prev_valid = '0;
  logic [N-1:0]     prev_ready = '0;
  logic [N-1:0]     drop_mask = '1;
  logic [26:0]      bump = '0;
  bit               real_mode = 1'b0;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  exp_t             sb [$];
  int               gnt_log [$];
  int               gnt_cyc [$];

  isq_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_x         (i_x),
    .o_gnt       (o_gnt),
    .o_isq_x     (o_isq_x),
    .i_isq_y     (i_isq_y),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .i_rsp_ready (i_rsp_ready),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      i_x[27*k +: 27] = x_arr[k];
    end
  end

  function automatic real bits_to_real(input logic [31:0] b);
    real v;
    int  e;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [26:0] real_to_f27(input real y);
    real v;
    int  e;
    int  m;
    if (y <= 0.0) return 27'd0;
    v = y;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 262144.0);
    return {1'b0, 8'(e), 18'(m)};
  endfunction

  // Identity echo for routing checks; magic-constant inverse sqrt plus one Newton step otherwise.
  function automatic logic [26:0] pipe_fn(input logic [26:0] x);
    logic [31:0] x32;
    logic [31:0] y32;
    real         xr;
    real         yr;
    if (!real_mode || x == 27'd0) return x;
    x32 = {x, 5'd0};
    y32 = 32'h5f3759df - (x32 >> 1);
    xr  = bits_to_real(x32);
    yr  = bits_to_real(y32);
    yr  = yr * (1.5 - 0.5 * xr * yr * yr);
    return real_to_f27(yr);
  endfunction

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= pipe_fn(o_isq_x);
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end
  assign i_isq_y = pipe_q[LAT-1];

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Grants push expected captures; rising response-valid bits pop and compare them.
  always @(negedge i_clk) begin
    exp_t e;
    int   gid;
    if (!i_rst) begin
      sb.delete();
      prev_valid = '0;
      prev_ready = '0;
      gnt_seen   = '0;
    end else begin
      gnt_seen = o_gnt;
      if (o_gnt != '0) begin
        gid = 0;
        for (int k = 0; k < N; k++) if (o_gnt[k]) gid = k;
        check_output("gnt_onehot", $countones(o_gnt), 32'd1);
        check_output("isq_x_route", 32'(o_isq_x), 32'(x_arr[gid]));
        sb.push_back('{gid, pipe_fn(x_arr[gid]), cyc + LAT + 1});
        gnt_log.push_back(gid);
        gnt_cyc.push_back(cyc);
      end else begin
        check_output("isq_x_idle", 32'(o_isq_x), 32'd0);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check_output("no_full_capture", 32'(prev_valid[sb[0].id] & ~prev_ready[sb[0].id]), 32'd0);
      end
      for (int k = 0; k < N; k++) begin
        if (o_rsp_valid[k] && !prev_valid[k]) begin
          if (sb.size() == 0) begin
            check_output("capture_unexpected", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check_output("capture_id", k, e.id);
            check_output("capture_data", 32'(o_rsp_data[27*k +: 27]), 32'(e.data));
            check_output("capture_cycle", cyc, e.due);
          end
        end
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check_output("capture_missing", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      prev_valid = o_rsp_valid;
      prev_ready = i_rsp_ready;
    end
  end

  // Requesters drop (per drop_mask) and advance their operand once granted.
  task automatic step();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (gnt_seen[k]) begin
        if (drop_mask[k]) i_req[k] = 1'b0;
        x_arr[k] = x_arr[k] + bump;
      end
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    #1;
  endtask

  task automatic apply_stimulus();
    step();
    sample();
  endtask

  task automatic apply_reset();
    i_rst       = 1'b0;
    i_req       = '0;
    i_rsp_ready = '0;
    step();
    sample();
    check_output("rst_gnt", 32'(o_gnt), 32'd0);
    check_output("rst_isq_x", 32'(o_isq_x), 32'd0);
    check_output("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_output("rst_rsp_data", 32'(|o_rsp_data), 32'd0);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    step();
    i_rst = 1'b1;
    sample();
  endtask

  initial begin
    int          g;
    int          n;
    int          base;
    int          cnt2;
    int          pat [3];
    logic [26:0] d0;
    logic [26:0] diff;
    pat[0] = 0; pat[1] = 1; pat[2] = 3;
    for (int k = 0; k < N; k++) x_arr[k] = '0;
    #3;

    // Single request through the inverse-sqrt model
    real_mode = 1'b1;
    drop_mask = '1;
    bump      = '0;
    apply_reset();
    step();
    x_arr[0] = 27'h2040000;
    i_req    = 4'b0001;
    sample();
    check_output("single_gnt", 32'(o_gnt), 32'h1);
    check_output("busy_before_issue", 32'(o_busy), 32'd0);
    g = cyc;
    apply_stimulus();
    check_output("busy_in_flight", 32'(o_busy), 32'd1);
    n = 0;
    while (!o_rsp_valid[0] && n < 20) begin
      apply_stimulus();
      n++;
    end
    check_output("single_latency", cyc - g, LAT + 1);
    d0   = o_rsp_data[26:0];
    diff = (d0 > 27'h1F80000) ? d0 - 27'h1F80000 : 27'h1F80000 - d0;
    check_output("isqrt_value_tol", 32'(diff <= 27'h800), 32'd1);
    step();
    i_rsp_ready = 4'b0001;
    sample();
    check_output("rsp_valid_hold", 32'(o_rsp_valid[0]), 32'd1);
    step();
    i_rsp_ready = '0;
    sample();
    check_output("rsp_valid_clear", 32'(o_rsp_valid[0]), 32'd0);
    check_output("rsp_data_hold", 32'(o_rsp_data[26:0]), 32'(d0));
    check_output("busy_idle", 32'(o_busy), 32'd0);
    real_mode = 1'b0;

    // All four from reset, ready held high
    apply_reset();
    i_rsp_ready = '1;
    base = gnt_log.size();
    step();
    for (int k = 0; k < N; k++) x_arr[k] = 27'(k + 1);
    i_req = 4'b1111;
    sample();
    repeat (15) apply_stimulus();
    check_output("all4_gnt_count", gnt_log.size() - base, 4);
    for (int k = 0; k < N; k++) begin
      check_output("all4_gnt_order", gnt_log[base+k], k);
      check_output("all4_gnt_spacing", gnt_cyc[base+k] - gnt_cyc[base], k);
    end

    // Requester 2 never consumes; others keep rotating
    apply_reset();
    drop_mask   = '0;
    bump        = 27'h100;
    i_rsp_ready = 4'b1011;
    base = gnt_log.size();
    step();
    for (int k = 0; k < N; k++) x_arr[k] = 27'(k + 1);
    i_req = 4'b1111;
    sample();
    repeat (40) apply_stimulus();
    cnt2 = 0;
    for (int i = base; i < gnt_log.size(); i++) if (gnt_log[i] == 2) cnt2++;
    check_output("stuck_gnt2_once", cnt2, 1);
    for (int i = base + 4; i < gnt_log.size(); i++) begin
      check_output("stuck_rotation", gnt_log[i], pat[(i - base - 4) % 3]);
    end
    check_output("stuck_valid2", 32'(o_rsp_valid[2]), 32'd1);
    check_output("stuck_data2", 32'(o_rsp_data[2*27 +: 27]), 32'd3);
    step();
    i_req = '0;
    sample();
    repeat (12) apply_stimulus();
    drop_mask = '1;
    bump      = '0;

    // Handshake and new request on requester 1 in the same cycle
    apply_reset();
    step();
    x_arr[1] = 27'h0ABCDE;
    i_req    = 4'b0010;
    sample();
    check_output("hs_first_gnt", 32'(o_gnt), 32'h2);
    repeat (LAT) apply_stimulus();
    step();
    i_req[1]       = 1'b1;
    i_rsp_ready[1] = 1'b1;
    sample();
    check_output("hs_valid", 32'(o_rsp_valid[1]), 32'd1);
    check_output("hs_no_gnt", 32'(o_gnt), 32'd0);
    step();
    i_rsp_ready = '0;
    sample();
    check_output("hs_regrant", 32'(o_gnt), 32'h2);
    check_output("hs_valid_clear", 32'(o_rsp_valid[1]), 32'd0);
    repeat (10) apply_stimulus();

    // Request dropped before grant leaves no trace
    apply_reset();
    i_rsp_ready = '1;
    step();
    x_arr[0] = 27'd5;
    x_arr[1] = 27'd6;
    i_req    = 4'b0011;
    sample();
    check_output("drop_first_gnt", 32'(o_gnt), 32'h1);
    step();
    i_req[1] = 1'b0;
    sample();
    check_output("drop_no_gnt", 32'(o_gnt), 32'd0);
    base = gnt_log.size();
    repeat (8) apply_stimulus();
    check_output("drop_no_later_gnt", gnt_log.size() - base, 0);
    step();
    x_arr[1] = 27'd7;
    x_arr[3] = 27'd9;
    i_req    = 4'b1010;
    sample();
    check_output("rr_after_drop", 32'(o_gnt), 32'h2);
    apply_stimulus();
    check_output("rr_next", 32'(o_gnt), 32'h8);
    repeat (10) apply_stimulus();

    // Reset in the middle of two in-flight operations
    apply_reset();
    step();
    x_arr[0] = 27'h11;
    x_arr[1] = 27'h22;
    i_req    = 4'b0011;
    sample();
    check_output("mid_gnt0", 32'(o_gnt), 32'h1);
    apply_stimulus();
    check_output("mid_gnt1", 32'(o_gnt), 32'h2);
    apply_stimulus();
    step();
    i_rst = 1'b0;
    sample();
    check_output("mid_rst_gnt", 32'(o_gnt), 32'd0);
    check_output("mid_rst_isq_x", 32'(o_isq_x), 32'd0);
    check_output("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    check_output("mid_rst_data", 32'(|o_rsp_data), 32'd0);
    check_output("mid_rst_busy", 32'(o_busy), 32'd0);
    apply_stimulus();
    step();
    i_rst = 1'b1;
    sample();
    for (int i = 0; i < LAT + 3; i++) begin
      apply_stimulus();
      check_output("post_rst_valid", 32'(o_rsp_valid), 32'd0);
      check_output("post_rst_busy", 32'(o_busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
